// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared FSM state type and width helpers for the nibble-serial adder
package nibble_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nib_count(input int w);
    return w / 4;
  endfunction
  function automatic int idx_width(input int w);
    return (w / 4 > 1) ? $clog2(w / 4) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead slice (PG generator, CLA, sum)
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:0] c,
  output logic       cout
);
  logic [3:0] p, g;
  assign p = x ^ y;
  assign g = x & y;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ c;
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract computed one nibble per clock through one CLA slice
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NIB = nib_count(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, sum_n;
  logic [IW-1:0] idx;
  logic carry, last, slice_cout;
  logic [3:0] s, c;
  assign last = idx == LAST;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  cla4_slice u_slice (
    .x(a[4*idx +: 4]),
    .y(b[4*idx +: 4]),
    .cin(carry),
    .s(s),
    .c(c),
    .cout(slice_cout)
  );
  // full result as it will look after this cycle's nibble lands, used for zero
  always_comb begin
    sum_n = sum;
    sum_n[4*idx +: 4] = s;
  end
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            :                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a     <= op_a;
        b     <= sub ? ~op_b : op_b;
        carry <= sub;
        idx   <= '0;
      end else if (state == RUN) begin
        sum   <= sum_n;
        carry <= slice_cout;
        idx   <= idx + 1'b1;
        if (last) begin
          cout <= slice_cout;
          ovf  <= c[3] ^ slice_cout;
          zero <= sum_n == '0;
        end
      end
    end
  end
endmodule
